// File: rtl/pe_agu_stream.sv
// Address generation unit for the sparse MAC array: walks a ping-pong index buffer and
// streams one data/parameter/accumulate address tuple per accepted beat.
module pe_agu_stream #(
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned IDX_W      = 8,
    parameter int unsigned IDX_DEPTH  = 256,
    parameter int unsigned IDX_ADDR_W = $clog2(IDX_DEPTH),
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned CNT_W      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  switch_idx_buf,
    input  logic [IDX_ADDR_W-1:0] idx_wr_addr,
    input  logic [2*IDX_W-1:0]    idx_wr_data,
    input  logic                  idx_wr_en,
    input  logic                  start,
    input  logic [1:0]            mode,
    input  logic [CNT_W-1:0]      idx_cnt,
    input  logic [CNT_W-1:0]      trip_cnt,
    input  logic                  is_new,
    input  logic [ADDR_W-1:0]     dbuf_base,
    input  logic [ADDR_W-1:0]     pbuf_base,
    input  logic [ADDR_W-1:0]     abuf_base,
    input  logic [ADDR_W-1:0]     pad_lo,
    input  logic [ADDR_W-1:0]     pad_hi,
    input  logic [NUM_CH-1:0]     ch_mask,
    output logic                  done,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_W-1:0]     dbuf_addr,
    output logic                  dbuf_mask,
    output logic [ADDR_W-1:0]     pbuf_addr,
    output logic                  mac_new_acc,
    output logic [ADDR_W-1:0]     abuf_addr,
    output logic [NUM_CH-1:0]     abuf_acc_en,
    output logic                  abuf_acc_new
);

    localparam int unsigned XW = ADDR_W + 1;

    typedef enum logic [1:0] {StIdle, StLoad, StRun} state_e;

    state_e               state_q, state_d;
    logic [2*IDX_W-1:0]   bank0 [IDX_DEPTH];
    logic [2*IDX_W-1:0]   bank1 [IDX_DEPTH];
    logic [2*IDX_W-1:0]   rd_entry;
    logic [IDX_W-1:0]     rd_p, rd_d, idx_p_q, idx_d_q, cur_p, cur_d;
    logic                 rd_bank_q, pend_q, pend_d, swap;
    logic [CNT_W-1:0]     ptr_q, ptr_d, t_q, t_d, cur_t;
    logic                 done_d, out_valid_d, cfg_load, tuple_load;
    logic [1:0]           mode_q;
    logic [CNT_W-1:0]     idx_cnt_q, trip_cnt_q;
    logic                 is_new_q;
    logic [ADDR_W-1:0]    dbuf_base_q, pbuf_base_q, abuf_base_q, pad_lo_q, pad_hi_q;
    logic [NUM_CH-1:0]    ch_mask_q;
    logic                 fc;
    logic [XW-1:0]        x;
    logic [ADDR_W-1:0]    dbuf_n, pbuf_n, abuf_n;
    logic                 mask_n, new_acc_n, acc_new_n;

    // Index banks: writes always land in the bank that is not being read.
    always_ff @(posedge clk) begin
        if (idx_wr_en) begin
            if (rd_bank_q) bank0[idx_wr_addr] <= idx_wr_data;
            else           bank1[idx_wr_addr] <= idx_wr_data;
        end
    end

    assign rd_entry = rd_bank_q ? bank1[IDX_ADDR_W'(ptr_q)] : bank0[IDX_ADDR_W'(ptr_q)];
    assign rd_p     = rd_entry[2*IDX_W-1:IDX_W];
    assign rd_d     = rd_entry[IDX_W-1:0];

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        t_d         = t_q;
        done_d      = done;
        out_valid_d = out_valid;
        pend_d      = pend_q;
        swap        = 1'b0;
        cfg_load    = 1'b0;
        tuple_load  = 1'b0;
        cur_p       = idx_p_q;
        cur_d       = idx_d_q;
        cur_t       = t_q;
        unique case (state_q)
            StIdle: begin
                swap = switch_idx_buf;
                if (start) begin
                    cfg_load = 1'b1;
                    ptr_d    = '0;
                    t_d      = '0;
                    done_d   = 1'b0;
                    state_d  = StLoad;
                end
            end
            StLoad: begin
                pend_d = pend_q | switch_idx_buf;
                if (idx_cnt_q == '0 || trip_cnt_q == '0) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end else begin
                    // Tuple for t=0 comes straight from the buffer read.
                    cur_p       = rd_p;
                    cur_d       = rd_d;
                    tuple_load  = 1'b1;
                    out_valid_d = 1'b1;
                    state_d     = StRun;
                end
            end
            StRun: begin
                pend_d = pend_q | switch_idx_buf;
                if (out_ready) begin
                    if (t_q == trip_cnt_q - 1'b1) begin
                        out_valid_d = 1'b0;
                        if (ptr_q == idx_cnt_q - 1'b1) begin
                            state_d = StIdle;
                            done_d  = 1'b1;
                        end else begin
                            ptr_d   = ptr_q + 1'b1;
                            t_d     = '0;
                            state_d = StLoad;
                        end
                    end else begin
                        t_d        = t_q + 1'b1;
                        cur_t      = t_q + 1'b1;
                        tuple_load = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        // Deferred bank swap lands on the edge that returns to idle.
        if (state_q != StIdle && state_d == StIdle) begin
            swap   = pend_q | switch_idx_buf;
            pend_d = 1'b0;
        end
    end

    always_comb begin
        fc        = mode_q[0];
        x         = XW'(cur_d) + (XW'(cur_t) << (mode_q == 2'b10));
        dbuf_n    = dbuf_base_q + x[ADDR_W-1:0];
        pbuf_n    = pbuf_base_q + ADDR_W'(cur_p);
        abuf_n    = abuf_base_q + (fc ? ADDR_W'(cur_d) : ADDR_W'(cur_t));
        mask_n    = !fc && (x < {1'b0, pad_lo_q} || x > {1'b0, pad_hi_q});
        new_acc_n = (cur_t == '0);
        acc_new_n = is_new_q && (ptr_q == '0);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= StIdle;
            ptr_q        <= '0;
            t_q          <= '0;
            done         <= 1'b1;
            out_valid    <= 1'b0;
            rd_bank_q    <= 1'b0;
            pend_q       <= 1'b0;
            mode_q       <= '0;
            idx_cnt_q    <= '0;
            trip_cnt_q   <= '0;
            is_new_q     <= 1'b0;
            dbuf_base_q  <= '0;
            pbuf_base_q  <= '0;
            abuf_base_q  <= '0;
            pad_lo_q     <= '0;
            pad_hi_q     <= '0;
            ch_mask_q    <= '0;
            idx_p_q      <= '0;
            idx_d_q      <= '0;
            dbuf_addr    <= '0;
            dbuf_mask    <= 1'b0;
            pbuf_addr    <= '0;
            mac_new_acc  <= 1'b0;
            abuf_addr    <= '0;
            abuf_acc_en  <= '0;
            abuf_acc_new <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            t_q       <= t_d;
            done      <= done_d;
            out_valid <= out_valid_d;
            pend_q    <= pend_d;
            rd_bank_q <= rd_bank_q ^ swap;
            if (cfg_load) begin
                mode_q      <= mode;
                idx_cnt_q   <= idx_cnt;
                trip_cnt_q  <= trip_cnt;
                is_new_q    <= is_new;
                dbuf_base_q <= dbuf_base;
                pbuf_base_q <= pbuf_base;
                abuf_base_q <= abuf_base;
                pad_lo_q    <= pad_lo;
                pad_hi_q    <= pad_hi;
                ch_mask_q   <= ch_mask;
            end
            if (state_q == StLoad) begin
                idx_p_q <= rd_p;
                idx_d_q <= rd_d;
            end
            if (tuple_load) begin
                dbuf_addr    <= dbuf_n;
                dbuf_mask    <= mask_n;
                pbuf_addr    <= pbuf_n;
                mac_new_acc  <= new_acc_n;
                abuf_addr    <= abuf_n;
                abuf_acc_en  <= ch_mask_q;
                abuf_acc_new <= acc_new_n;
            end
        end
    end

endmodule

// File: tb/tb_pe_agu_stream.sv
// Directed bench for pe_agu_stream: per-cycle capture of each run compared against
// hand-computed tuple tables.
module tb_pe_agu_stream;

    logic        clk = 1'b0;
    logic        rst, switch_idx_buf, idx_wr_en, start, is_new, out_ready;
    logic [7:0]  idx_wr_addr, idx_cnt, trip_cnt;
    logic [15:0] idx_wr_data;
    logic [1:0]  mode;
    logic [7:0]  dbuf_base, pbuf_base, abuf_base, pad_lo, pad_hi;
    logic [3:0]  ch_mask, abuf_acc_en;
    logic        done, out_valid, dbuf_mask, mac_new_acc, abuf_acc_new;
    logic [7:0]  dbuf_addr, pbuf_addr, abuf_addr;

    int errors = 0;
    int checks = 0;

    logic       cv[64], cm[64], cn[64], can[64];
    logic [7:0] cd[64], cp[64], ca[64];
    logic [3:0] cae[64];
    int         last_k, nbeats;
    int         ev[$], ed[$], ep[$], ea[$], em[$], en[$], ean[$];

    pe_agu_stream dut (
        .clk(clk), .rst(rst), .switch_idx_buf(switch_idx_buf), .idx_wr_addr(idx_wr_addr),
        .idx_wr_data(idx_wr_data), .idx_wr_en(idx_wr_en), .start(start), .mode(mode),
        .idx_cnt(idx_cnt), .trip_cnt(trip_cnt), .is_new(is_new), .dbuf_base(dbuf_base),
        .pbuf_base(pbuf_base), .abuf_base(abuf_base), .pad_lo(pad_lo), .pad_hi(pad_hi),
        .ch_mask(ch_mask), .done(done), .out_valid(out_valid), .out_ready(out_ready),
        .dbuf_addr(dbuf_addr), .dbuf_mask(dbuf_mask), .pbuf_addr(pbuf_addr),
        .mac_new_acc(mac_new_acc), .abuf_addr(abuf_addr), .abuf_acc_en(abuf_acc_en),
        .abuf_acc_new(abuf_acc_new)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [15:0] dat);
        idx_wr_addr = a;
        idx_wr_data = dat;
        idx_wr_en   = 1'b1;
        tick();
        idx_wr_en   = 1'b0;
    endtask

    task automatic cfg(input logic [1:0] md, input logic [7:0] ic, input logic [7:0] tc,
                       input logic nw, input logic [7:0] db, input logic [7:0] pb,
                       input logic [7:0] ab, input logic [7:0] lo, input logic [7:0] hi,
                       input logic [3:0] cm_i);
        mode = md; idx_cnt = ic; trip_cnt = tc; is_new = nw;
        dbuf_base = db; pbuf_base = pb; abuf_base = ab;
        pad_lo = lo; pad_hi = hi; ch_mask = cm_i;
    endtask

    // Pulse start, then record every cycle until done rises (k=0 is the start edge).
    task automatic capture(input int budget, input int stall_from, input int stall_len,
                           input int sw_at, input int wr_at);
        nbeats = 0;
        last_k = -1;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        for (int k = 0; k <= budget; k++) begin
            if (k > 0) tick();
            out_ready      = !(k >= stall_from && k < stall_from + stall_len);
            switch_idx_buf = (k == sw_at);
            idx_wr_en      = (k == wr_at);
            cv[k] = out_valid; cd[k] = dbuf_addr; cp[k] = pbuf_addr; ca[k] = abuf_addr;
            cm[k] = dbuf_mask; cn[k] = mac_new_acc; can[k] = abuf_acc_new;
            cae[k] = abuf_acc_en;
            if (out_valid && out_ready) nbeats++;
            if (done && k > 0) begin
                last_k = k;
                break;
            end
        end
        switch_idx_buf = 1'b0;
        idx_wr_en      = 1'b0;
        out_ready      = 1'b1;
    endtask

    task automatic verify(input string tag, input int done_at, input int beats,
                          input logic [3:0] acc_en);
        check($sformatf("%s_done_at", tag), last_k, done_at);
        check($sformatf("%s_beats", tag), nbeats, beats);
        for (int k = 0; k < ev.size(); k++) begin
            check($sformatf("%s_valid%0d", tag, k), cv[k], ev[k]);
            if (ev[k] != 0) begin
                check($sformatf("%s_dbuf%0d", tag, k), cd[k], ed[k]);
                check($sformatf("%s_pbuf%0d", tag, k), cp[k], ep[k]);
                check($sformatf("%s_abuf%0d", tag, k), ca[k], ea[k]);
                check($sformatf("%s_mask%0d", tag, k), cm[k], em[k]);
                check($sformatf("%s_newacc%0d", tag, k), cn[k], en[k]);
                check($sformatf("%s_accnew%0d", tag, k), can[k], ean[k]);
                check($sformatf("%s_accen%0d", tag, k), cae[k], acc_en);
            end
        end
    endtask

    initial begin
        rst = 1'b0; switch_idx_buf = 1'b0; idx_wr_en = 1'b0; start = 1'b0; out_ready = 1'b1;
        idx_wr_addr = '0; idx_wr_data = '0;
        cfg(2'b00, 8'd0, 8'd3, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 4'hF);
        tick();
        tick();
        check("rst_done", done, 1);
        check("rst_valid", out_valid, 0);
        check("rst_dbuf", dbuf_addr, 0);
        check("rst_pbuf", pbuf_addr, 0);
        check("rst_abuf", abuf_addr, 0);
        check("rst_mask", dbuf_mask, 0);
        check("rst_newacc", mac_new_acc, 0);
        check("rst_accen", abuf_acc_en, 0);
        check("rst_accnew", abuf_acc_new, 0);
        rst = 1'b1;
        tick();

        // idx_cnt=0: LOAD then straight back to idle, no beats.
        start = 1'b1;
        tick();
        start = 1'b0;
        check("zero_done_low", done, 0);
        check("zero_valid0", out_valid, 0);
        tick();
        check("zero_done_high", done, 1);
        check("zero_valid1", out_valid, 0);
        check("zero_dbuf", dbuf_addr, 0);
        check("zero_accen", abuf_acc_en, 0);
        check("zero_newacc", mac_new_acc, 0);

        // Fill write bank (1), swap while idle, then fill the new write bank (0).
        wr(8'd0, {8'd3, 8'd5});
        wr(8'd1, {8'd7, 8'd1});
        switch_idx_buf = 1'b1;
        tick();
        switch_idx_buf = 1'b0;
        wr(8'd0, {8'd9, 8'd3});
        wr(8'd1, {8'd11, 8'd77});

        // Run A: conv stride 1, zero bases.
        cfg(2'b00, 8'd2, 8'd3, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 4'b1010);
        capture(40, 99, 0, -1, -1);
        ev = '{0, 1, 1, 1, 0, 1, 1, 1};
        ed = '{0, 5, 6, 7, 0, 1, 2, 3};
        ep = '{0, 3, 3, 3, 0, 7, 7, 7};
        ea = '{0, 0, 1, 2, 0, 0, 1, 2};
        em = '{0, 0, 0, 0, 0, 0, 0, 0};
        en = '{0, 1, 0, 0, 0, 1, 0, 0};
        ean = '{0, 0, 0, 0, 0, 0, 0, 0};
        verify("runA", 8, 6, 4'b1010);

        // Run B: conv stride 2 with padding window and non-zero bases.
        cfg(2'b10, 8'd2, 8'd3, 1'b1, 8'h40, 8'h20, 8'h10, 8'd2, 8'd8, 4'b0111);
        capture(40, 99, 0, -1, -1);
        ev = '{0, 1, 1, 1, 0, 1, 1, 1};
        ed = '{0, 'h45, 'h47, 'h49, 0, 'h41, 'h43, 'h45};
        ep = '{0, 'h23, 'h23, 'h23, 0, 'h27, 'h27, 'h27};
        ea = '{0, 'h10, 'h11, 'h12, 0, 'h10, 'h11, 'h12};
        em = '{0, 0, 0, 1, 0, 1, 0, 0};
        en = '{0, 1, 0, 0, 0, 1, 0, 0};
        ean = '{0, 1, 1, 1, 0, 0, 0, 0};
        verify("runB", 8, 6, 4'b0111);

        // Run C: 4-cycle stall, mid-run switch request and write into the write bank.
        cfg(2'b00, 8'd2, 8'd3, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 4'hF);
        idx_wr_addr = 8'd1;
        idx_wr_data = {8'd10, 8'd30};
        capture(40, 2, 4, 3, 4);
        ev = '{0, 1, 1, 1, 1, 1, 1, 1, 0, 1, 1, 1};
        ed = '{0, 5, 6, 6, 6, 6, 6, 7, 0, 1, 2, 3};
        ep = '{0, 3, 3, 3, 3, 3, 3, 3, 0, 7, 7, 7};
        ea = '{0, 0, 1, 1, 1, 1, 1, 2, 0, 0, 1, 2};
        em = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        en = '{0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
        ean = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        verify("runC", 12, 6, 4'hF);

        // Run D: fc mode on the swapped-in bank; dbuf base wraps, padding ignored.
        cfg(2'b01, 8'd2, 8'd2, 1'b1, 8'hFE, 8'h00, 8'h10, 8'h80, 8'h81, 4'b1100);
        capture(40, 99, 0, -1, -1);
        ev = '{0, 1, 1, 0, 1, 1};
        ed = '{0, 'h01, 'h02, 0, 'h1C, 'h1D};
        ep = '{0, 9, 9, 0, 10, 10};
        ea = '{0, 'h13, 'h13, 0, 'h2E, 'h2E};
        em = '{0, 0, 0, 0, 0, 0};
        en = '{0, 1, 0, 0, 1, 0};
        ean = '{0, 1, 1, 0, 0, 0};
        verify("runD", 6, 4, 4'b1100);

        // Reset in the middle of a run aborts it.
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("abort_valid_before", out_valid, 1);
        check("abort_dbuf_before", dbuf_addr, 8'h01);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("abort_valid", out_valid, 0);
        check("abort_done", done, 1);
        check("abort_dbuf", dbuf_addr, 0);
        check("abort_accen", abuf_acc_en, 0);
        tick();
        check("abort_stay_idle", out_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
